// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: FSM states, requester id and the
// latched memory request.
package dmem_arb_pkg;

  localparam int NUM_REQ = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    STORE   = 2'd2,
    RECOVER = 2'd3
  } arb_state_t;

  typedef logic req_id_t;

  typedef struct packed {
    logic        write;
    logic [31:0] address;
    logic [31:0] storeData;
    logic [3:0]  byteEnable;
  } mem_req_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester-side and memory-side signals of the data-memory arbiter.
// slave = arbiter view; master = the requesters plus the memory driving it.
interface dmem_arbiter_if;
  import dmem_arb_pkg::*;

  // Handshake: a requester raises reqValid[i] with its command and holds both
  // unchanged-in-intent until the one-cycle reqDone[i] pulse; reqError[i] and
  // reqLoadData are only meaningful in that pulse cycle.
  logic [NUM_REQ-1:0]       reqValid;
  logic [NUM_REQ-1:0]       reqWrite;
  logic [NUM_REQ-1:0][31:0] reqAddress;
  logic [NUM_REQ-1:0][31:0] reqStoreData;
  logic [NUM_REQ-1:0][3:0]  reqByteEnable;
  logic [NUM_REQ-1:0]       reqDone;
  logic [NUM_REQ-1:0]       reqError;
  logic [31:0]              reqLoadData;

  logic [31:0]              memAddress;
  logic [31:0]              memStoreData;
  logic [3:0]               memByteEnable;
  logic                     memStoreValid;
  logic [31:0]              memLoadData;
  logic                     memLoadDataValid;
  logic                     memStoreComplete;

  modport slave (
    input  reqValid, reqWrite, reqAddress, reqStoreData, reqByteEnable,
    input  memLoadData, memLoadDataValid, memStoreComplete,
    output reqDone, reqError, reqLoadData,
    output memAddress, memStoreData, memByteEnable, memStoreValid
  );

  modport master (
    output reqValid, reqWrite, reqAddress, reqStoreData, reqByteEnable,
    output memLoadData, memLoadDataValid, memStoreComplete,
    input  reqDone, reqError, reqLoadData,
    input  memAddress, memStoreData, memByteEnable, memStoreValid
  );

endinterface

// File: rtl/dmem_arb_select.sv
// Combinational grant among eligible requesters. DMEM_ARB_RR_EN selects
// round-robin (rr_ptr_i is the preferred requester); otherwise requester 0 wins.
module dmem_arb_select
  import dmem_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] eligible_i,
`ifdef DMEM_ARB_RR_EN
  input  req_id_t            rr_ptr_i,
`endif
  output logic               grant_valid_o,
  output req_id_t            grant_id_o
);

  always_comb begin
    grant_valid_o = |eligible_i;
`ifdef DMEM_ARB_RR_EN
    grant_id_o    = eligible_i[rr_ptr_i] ? rr_ptr_i : ~rr_ptr_i;
`else
    grant_id_o    = eligible_i[0] ? 1'b0 : 1'b1;
`endif
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Serialises two requesters onto the single Dmem port and runs the edge-triggered
// store protocol. Define DMEM_ARB_RR_EN for round-robin, else fixed priority.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int STORE_TIMEOUT = 16
) (
  input  logic           clock,
  input  logic           reset,
  dmem_arbiter_if.slave  bus,
  output arb_state_t     dbg_state_o
);

  localparam int CW = $clog2(STORE_TIMEOUT + 1);

  arb_state_t         state_q, state_d;
  req_id_t            id_q, id_d;
  mem_req_t           req_q, req_d;
  logic [CW-1:0]      cnt_q, cnt_d, cnt_inc;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic [NUM_REQ-1:0] err_q, err_d;
  logic [31:0]        ld_q, ld_d;

  logic [NUM_REQ-1:0] eligible;
  logic               gnt_valid;
  req_id_t            gnt_id;

  // A requester still holding valid in its own done cycle is stale; skip it.
  assign eligible = bus.reqValid & ~done_q;
  assign cnt_inc  = cnt_q + CW'(1);

`ifdef DMEM_ARB_RR_EN
  req_id_t rr_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rr_q <= 1'b0;
    end else if (state_q == IDLE && gnt_valid) begin
      rr_q <= ~gnt_id;
    end
  end
`endif

  dmem_arb_select u_select (
    .eligible_i    (eligible),
`ifdef DMEM_ARB_RR_EN
    .rr_ptr_i      (rr_q),
`endif
    .grant_valid_o (gnt_valid),
    .grant_id_o    (gnt_id)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      id_q    <= 1'b0;
      req_q   <= '0;
      cnt_q   <= '0;
      done_q  <= '0;
      err_q   <= '0;
      ld_q    <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      req_q   <= req_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      ld_q    <= ld_d;
    end
  end

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    req_d   = req_q;
    cnt_d   = cnt_q;
    done_d  = '0;
    err_d   = '0;
    ld_d    = ld_q;
    unique case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          id_d             = gnt_id;
          req_d.write      = bus.reqWrite[gnt_id];
          req_d.address    = bus.reqAddress[gnt_id];
          req_d.storeData  = bus.reqStoreData[gnt_id];
          req_d.byteEnable = bus.reqByteEnable[gnt_id];
          state_d          = bus.reqWrite[gnt_id] ? STORE : LOAD;
        end
      end
      LOAD: begin
        if (bus.memLoadDataValid) begin
          ld_d         = bus.memLoadData;
          done_d[id_q] = 1'b1;
          state_d      = IDLE;
        end
      end
      STORE: begin
        cnt_d = cnt_inc;
        if (bus.memStoreComplete) begin
          done_d[id_q] = 1'b1;
          state_d      = RECOVER;
        end else if (cnt_inc == CW'(STORE_TIMEOUT)) begin
          done_d[id_q] = 1'b1;
          err_d[id_q]  = 1'b1;
          state_d      = RECOVER;
        end
      end
      RECOVER: begin
        // One low cycle of storeValid so the memory sees a fresh rising edge.
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.reqDone       = done_q;
  assign bus.reqError      = err_q;
  assign bus.reqLoadData   = ld_q;
  assign bus.memAddress    = req_q.address;
  assign bus.memStoreData  = req_q.storeData;
  assign bus.memByteEnable = req_q.byteEnable;
  assign bus.memStoreValid = (state_q == STORE) && req_q.write;
  assign dbg_state_o       = state_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed and randomised bench for dmem_arbiter with a word-array memory model
// and a transaction-level reference memory.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  localparam int T = 16;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  arb_state_t dbg_state;

  dmem_arbiter_if bus();

  dmem_arbiter #(.STORE_TIMEOUT(T)) dut (
    .clock       (clock),
    .reset       (reset),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  always #5 clock = ~clock;

  // ---------------- Dmem model: combinational load, store on storeValid rise
  logic [31:0] mem [0:255];
  logic        sv_prev, cmp_q;
  bit          never_complete = 1'b0;
  bit          ld_ok = 1'b1;
  bit          rnd_stall = 1'b0;
  int          store_edges;

  assign bus.memLoadData      = mem[bus.memAddress[9:2]];
  assign bus.memLoadDataValid = ld_ok;
  assign bus.memStoreComplete = cmp_q;

  always @(posedge clock) begin
    if (!reset) begin
      sv_prev     <= 1'b0;
      cmp_q       <= 1'b0;
      store_edges <= 0;
      for (int i = 0; i < 256; i++) mem[i] <= '0;
    end else begin
      sv_prev <= bus.memStoreValid;
      cmp_q   <= 1'b0;
      if (bus.memStoreValid && !sv_prev) begin
        store_edges <= store_edges + 1;
        if (!never_complete) begin
          for (int b = 0; b < 4; b++)
            if (bus.memByteEnable[b]) mem[bus.memAddress[9:2]][8*b +: 8] <= bus.memStoreData[8*b +: 8];
          cmp_q <= 1'b1;
        end
      end
    end
  end

  // ---------------- scoreboard state
  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] ref_mem [0:255];
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic ref_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    for (int b = 0; b < 4; b++)
      if (be[b]) ref_mem[a[9:2]][8*b +: 8] = d[8*b +: 8];
  endtask

  // One request from requester id, starting at a negedge, returning at the
  // negedge where its reqDone is seen (or the cycle budget runs out).
  task automatic txn(input int id, input bit wr, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] be, input bit scramble,
                     output int lat, output logic err, output logic [31:0] ld,
                     output int sv_cnt, output logic sv_at_done);
    bus.reqValid[id]      = 1'b1;
    bus.reqWrite[id]      = wr;
    bus.reqAddress[id]    = a;
    bus.reqStoreData[id]  = d;
    bus.reqByteEnable[id] = be;
    lat    = 0;
    sv_cnt = 0;
    do begin
      @(negedge clock);
      lat++;
      if (bus.memStoreValid) sv_cnt++;
      if (scramble) begin
        bus.reqAddress[id]    = $urandom();
        bus.reqStoreData[id]  = $urandom();
        bus.reqByteEnable[id] = 4'($urandom());
      end
      ld_ok = rnd_stall ? 1'($urandom_range(0, 2) != 0) : 1'b1;
    end while (!bus.reqDone[id] && lat < T + 40);
    check("done_seen", 32'(bus.reqDone[id]), 32'd1);
    err        = bus.reqError[id];
    ld         = bus.reqLoadData;
    sv_at_done = bus.memStoreValid;
    bus.reqValid[id] = 1'b0;
    ld_ok = 1'b1;
    if (wr && bus.reqDone[id] && !err) ref_store(a, d, be);
  endtask

  // Both requesters hold valid continuously; after four completions each one
  // drops valid at its next completion. Completion order lands in got_q.
  task automatic contend(input bit wr, input logic [31:0] a0, input logic [31:0] a1,
                         input logic [31:0] d0, input logic [31:0] d1);
    int guard;
    bit stop;
    logic [31:0] ad [2];
    logic [31:0] dd [2];
    ad[0] = a0; ad[1] = a1; dd[0] = d0; dd[1] = d1;
    got_q.delete();
    for (int i = 0; i < 2; i++) begin
      bus.reqWrite[i]      = wr;
      bus.reqAddress[i]    = ad[i];
      bus.reqStoreData[i]  = dd[i];
      bus.reqByteEnable[i] = 4'hF;
    end
    bus.reqValid = 2'b11;
    guard = 0;
    stop  = 1'b0;
    while (bus.reqValid != 2'b00 && guard < 200) begin
      @(negedge clock);
      guard++;
      for (int i = 0; i < 2; i++) begin
        if (bus.reqDone[i]) begin
          got_q.push_back(32'(i));
          if (!wr) check("cont_ld_data", bus.reqLoadData, ref_mem[ad[i][9:2]]);
          else ref_store(ad[i], dd[i], 4'hF);
          if (stop) bus.reqValid[i] = 1'b0;
        end
      end
      if (got_q.size() >= 4) stop = 1'b1;
    end
    check("cont_drain", 32'(guard < 200), 32'd1);
    for (int i = 0; i < 4; i++)
      check(wr ? "cont_st_grant" : "cont_ld_grant",
            (got_q.size() > i) ? got_q[i] : 32'hFFFF_FFFF, exp_q[i]);
  endtask

  int          lat, sv_cnt, e0, id;
  logic        err, sva;
  bit          wr;
  logic [31:0] ld, a, d, expd;
  logic [3:0]  be;

  initial begin
    bus.reqValid      = '0;
    bus.reqWrite      = '0;
    bus.reqAddress    = '0;
    bus.reqStoreData  = '0;
    bus.reqByteEnable = '0;
    for (int i = 0; i < 256; i++) ref_mem[i] = '0;

    // Reset state
    repeat (3) @(negedge clock);
    check("rst_done",  32'(bus.reqDone), 32'd0);
    check("rst_err",   32'(bus.reqError), 32'd0);
    check("rst_ldata", bus.reqLoadData, 32'd0);
    check("rst_sv",    32'(bus.memStoreValid), 32'd0);
    check("rst_addr",  bus.memAddress, 32'd0);
    check("rst_sdata", bus.memStoreData, 32'd0);
    check("rst_be",    32'(bus.memByteEnable), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    reset = 1'b1;
    @(negedge clock);

    // Load: preload word through the arbiter, then a plain load with N+2 latency
    txn(1, 1'b1, 32'h100, 32'hDEAD_BEEF, 4'hF, 1'b0, lat, err, ld, sv_cnt, sva);
    @(negedge clock);
    txn(0, 1'b0, 32'h100, 32'h0, 4'h0, 1'b1, lat, err, ld, sv_cnt, sva);
    check("load_lat",  32'(lat), 32'd2);
    check("load_data", ld, 32'hDEAD_BEEF);
    check("load_err",  32'(err), 32'd0);
    check("load_sv",   32'(sv_cnt), 32'd0);
    @(negedge clock);

    // Partial store with byte lanes 0011 over a known word
    txn(1, 1'b1, 32'h200, 32'hAABB_CCDD, 4'hF, 1'b0, lat, err, ld, sv_cnt, sva);
    @(negedge clock);
    e0 = store_edges;
    txn(1, 1'b1, 32'h200, 32'h1122_3344, 4'b0011, 1'b1, lat, err, ld, sv_cnt, sva);
    check("store_lat",     32'(lat), 32'd3);
    check("store_err",     32'(err), 32'd0);
    check("store_sv_cyc",  32'(sv_cnt), 32'd2);
    check("store_recover_sv", 32'(sva), 32'd0);
    check("store_recover", 32'(dbg_state), 32'(RECOVER));
    @(negedge clock);
    check("store_idle",    32'(dbg_state), 32'(IDLE));
    check("store_edges",   32'(store_edges - e0), 32'd1);
    txn(1, 1'b0, 32'h200, 32'h0, 4'h0, 1'b0, lat, err, ld, sv_cnt, sva);
    check("store_readback", ld, 32'hAABB_3344);
    @(negedge clock);

    // Load contention: the holder is masked in its done cycle, so grants
    // alternate in either arbitration mode.
    exp_q = '{32'd0, 32'd1, 32'd0, 32'd1};
    contend(1'b0, 32'h100, 32'h200, 32'h0, 32'h0);
    repeat (2) @(negedge clock);

    // Store contention: RECOVER separates done from the next IDLE, so the
    // arbitration mode alone decides.
`ifdef DMEM_ARB_RR_EN
    exp_q = '{32'd0, 32'd1, 32'd0, 32'd1};
`else
    exp_q = '{32'd0, 32'd0, 32'd0, 32'd0};
`endif
    contend(1'b1, 32'h140, 32'h144, 32'h0A0A_0A0A, 32'h0B0B_0B0B);
    repeat (2) @(negedge clock);
    txn(1, 1'b0, 32'h144, 32'h0, 4'h0, 1'b0, lat, err, ld, sv_cnt, sva);
    check("cont_st_readback", ld, 32'h0B0B_0B0B);
    @(negedge clock);

    // Store timeout: memory never completes
    never_complete = 1'b1;
    e0 = store_edges;
    txn(0, 1'b1, 32'h180, 32'h5555_AAAA, 4'hF, 1'b0, lat, err, ld, sv_cnt, sva);
    check("tmo_lat",    32'(lat), 32'(T + 1));
    check("tmo_err",    32'(err), 32'd1);
    check("tmo_sv_cyc", 32'(sv_cnt), 32'(T));
    check("tmo_sv_off", 32'(sva), 32'd0);
    check("tmo_edges",  32'(store_edges - e0), 32'd1);
    never_complete = 1'b0;
    @(negedge clock);

    // Back-to-back stores from requester 0
    e0 = store_edges;
    txn(0, 1'b1, 32'h1C0, 32'h1234_5678, 4'hF, 1'b0, lat, err, ld, sv_cnt, sva);
    check("b2b_lat0", 32'(lat), 32'd3);
    check("b2b_err0", 32'(err), 32'd0);
    txn(0, 1'b1, 32'h1C4, 32'h9ABC_DEF0, 4'hF, 1'b0, lat, err, ld, sv_cnt, sva);
    check("b2b_lat1", 32'(lat), 32'd4);
    check("b2b_err1", 32'(err), 32'd0);
    check("b2b_edges", 32'(store_edges - e0), 32'd2);
    @(negedge clock);
    txn(0, 1'b0, 32'h1C0, 32'h0, 4'h0, 1'b0, lat, err, ld, sv_cnt, sva);
    check("b2b_rd0", ld, ref_mem[8'h70]);
    @(negedge clock);
    txn(1, 1'b0, 32'h1C4, 32'h0, 4'h0, 1'b0, lat, err, ld, sv_cnt, sva);
    check("b2b_rd1", ld, ref_mem[8'h71]);
    @(negedge clock);

    // Randomised single transactions against the reference memory
    rnd_stall = 1'b1;
    for (int k = 0; k < 40; k++) begin
      id   = $urandom_range(0, 1);
      wr   = 1'($urandom_range(0, 1));
      a    = 32'h300 + 32'($urandom_range(0, 15)) * 4;
      d    = $urandom();
      be   = 4'($urandom_range(0, 15));
      expd = ref_mem[a[9:2]];
      txn(id, wr, a, d, be, 1'b1, lat, err, ld, sv_cnt, sva);
      check("rnd_err", 32'(err), 32'd0);
      if (wr) begin
        check("rnd_st_lat", 32'(lat), 32'd3);
      end else begin
        check("rnd_ld_data", ld, expd);
        check("rnd_ld_lat", 32'(lat >= 2), 32'd1);
      end
      @(negedge clock);
    end
    rnd_stall = 1'b0;

    // Reset in the middle of a store
    never_complete = 1'b1;
    bus.reqValid[1]      = 1'b1;
    bus.reqWrite[1]      = 1'b1;
    bus.reqAddress[1]    = 32'h380;
    bus.reqStoreData[1]  = 32'hCAFE_F00D;
    bus.reqByteEnable[1] = 4'hF;
    repeat (2) @(negedge clock);
    check("rstm_pre_sv", 32'(bus.memStoreValid), 32'd1);
    #1 reset = 1'b0;
    #1;
    check("rstm_sv",    32'(bus.memStoreValid), 32'd0);
    check("rstm_done",  32'(bus.reqDone), 32'd0);
    check("rstm_state", 32'(dbg_state), 32'(IDLE));
    bus.reqValid = '0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    never_complete = 1'b0;
    for (int i = 0; i < 256; i++) ref_mem[i] = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("rstm_no_done", 32'(bus.reqDone), 32'd0);
    end
    check("rstm_idle", 32'(dbg_state), 32'(IDLE));
    txn(0, 1'b0, 32'h100, 32'h0, 4'h0, 1'b0, lat, err, ld, sv_cnt, sva);
    check("rstm_load_lat",  32'(lat), 32'd2);
    check("rstm_load_data", ld, ref_mem[8'h40]);

    repeat (2) @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
